// File: rtl/asic_st_packetizer.sv
// ASIC sample packetizer: captures ASIC status samples into a small FIFO and
// streams them as fixed-length Avalon-ST packets with a running error count
// and a forced inter-packet gap.
module asic_st_packetizer #(
  parameter int unsigned PKT_LEN    = 202,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IPG        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [6:0]  asic_tout,
  input  logic        asic_bitout,
  input  logic        asic_keepshift,
  input  logic        asic_start,
  input  logic        asic_testready,
  output logic [31:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_startofpacket,
  output logic        src_endofpacket,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned GW = (IPG > 1) ? $clog2(IPG) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StGap} state_e;

  // FIFO entry layout: {testready, start, keepshift, bitout, tout[6:0]}
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [10:0]   head;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [6:0]    err_q, err_d;
  logic [6:0]    err_beat;
  logic [GW-1:0] gap_q, gap_d;
  logic          idx_last, gap_last;
  logic          overflow_q;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign idx_last   = (idx_q == 8'(PKT_LEN - 1));
  assign gap_last   = (32'(gap_q) == IPG - 1);

  // A full FIFO still accepts a sample when a beat leaves in the same cycle.
  assign pop  = src_valid & src_ready;
  assign push = sample_valid & (~fifo_full | pop);

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {asic_testready, asic_start, asic_keepshift, asic_bitout, asic_tout};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (sample_valid && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Error count shown on the current beat: restarts at sop, saturates at 127.
  always_comb begin
    err_beat = err_q;
    if (idx_q == 8'd0) begin
      err_beat = 7'd0;
    end else if (head[8] && head[7] && (err_q != 7'd127)) begin
      err_beat = err_q + 7'd1;
    end
  end

  // Packet FSM next state: index, running error count and gap counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (enable && !fifo_empty) begin
          state_d = StStream;
          idx_d   = 8'd0;
        end
      end
      StStream: begin
        // Empty FIFO just stalls the packet; enable is ignored until eop.
        if (pop) begin
          err_d = err_beat;
          if (idx_last) begin
            idx_d   = 8'd0;
            gap_d   = '0;
            state_d = (IPG == 0) ? StIdle : StGap;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StGap: begin
        // The idle decision is folded into the last gap cycle so the low
        // time between packets is exactly IPG cycles.
        if (gap_last) begin
          gap_d   = '0;
          state_d = (enable && !fifo_empty) ? StStream : StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 8'd0;
      err_q   <= 7'd0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end

  // Source outputs depend only on registered state, never on src_ready.
  always_comb begin
    src_valid         = 1'b0;
    src_startofpacket = 1'b0;
    src_endofpacket   = 1'b0;
    src_data          = 32'd0;
    if ((state_q == StStream) && !fifo_empty && !reset) begin
      src_valid         = 1'b1;
      src_startofpacket = (idx_q == 8'd0);
      src_endofpacket   = idx_last;
      src_data          = {2'b00, head[10], 1'b0, head[9], head[8], 1'b0, head[7], 1'b0,
                           head[6:0], 9'd0, err_beat};
    end
  end

  assign overflow = overflow_q;

endmodule
